// File: rtl/run_sequencer_if.sv
//==============================================================================
// Module  : run_sequencer_if
// Brief   : Host feed, result drain and control-engine signal bundle.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface run_sequencer_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic request_in;
    logic status;
    logic rst_CE;

    // master = sequencer side, slave = host / control-engine side
    modport master (
        input  in_valid, out_ready, request_in, status,
        output in_ready, out_valid, rst_CE
    );
    modport slave (
        output in_valid, out_ready, request_in, status,
        input  in_ready, out_valid, rst_CE
    );
endinterface

`default_nettype wire

// File: rtl/run_sequencer.sv
//==============================================================================
// Module  : run_sequencer
// Brief   : Sequences control-engine runs over samples and epochs.
// Revision: 1.0
//==============================================================================
`default_nettype none

module run_sequencer #(
    parameter int unsigned RST_CYC = 2,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic        abort,
    input  wire logic        mode,
    input  wire logic [15:0] num_samples,
    input  wire logic [7:0]  num_epochs,
    run_sequencer_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [15:0]      sample_cnt,
    output logic [7:0]       epoch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RSTCE   = 3'd1,
        S_WAITREQ = 3'd2,
        S_FEED    = 3'd3,
        S_RUN     = 3'd4,
        S_DRAIN   = 3'd5,
        S_NEXT    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [15:0] c_RST_LAST = 16'(RST_CYC - 1);
    localparam logic [15:0] c_RUN_LAST = TIMEOUT - 16'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_mode;
    logic [15:0] r_num_samples;
    logic [7:0]  r_num_epochs;
    logic [15:0] r_rst_cnt;
    logic [15:0] r_run_cnt;
    logic        r_status_d;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_rst_ce;

    logic w_status_edge;
    logic w_last_sample;
    logic w_last_epoch;
    logic w_run_expired;

    assign w_status_edge = bus.status && !r_status_d;
    assign w_last_sample = (sample_cnt == r_num_samples - 16'd1);
    assign w_last_epoch  = (epoch_cnt == r_num_epochs - 8'd1);
    assign w_run_expired = (r_run_cnt == c_RUN_LAST);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.rst_CE    = r_rst_ce;

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = (num_samples == 16'd0 || num_epochs == 8'd0)
                                      ? S_DONE : S_RSTCE;
                    end
                end
                S_RSTCE:   if (r_rst_cnt == c_RST_LAST) w_state_nxt = S_WAITREQ;
                S_WAITREQ: if (bus.request_in) w_state_nxt = S_FEED;
                S_FEED:    if (bus.in_valid) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_status_edge)      w_state_nxt = r_mode ? S_NEXT : S_DRAIN;
                    else if (w_run_expired) w_state_nxt = S_DONE;
                end
                S_DRAIN:   if (bus.out_ready) w_state_nxt = S_NEXT;
                S_NEXT: begin
                    if (w_last_sample && (w_last_epoch || !r_mode)) w_state_nxt = S_DONE;
                    else                                           w_state_nxt = S_WAITREQ;
                end
                S_DONE:    w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with the state they decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_num_samples <= 16'd0;
            r_num_epochs  <= 8'd0;
            r_rst_cnt     <= 16'd0;
            r_run_cnt     <= 16'd0;
            r_status_d    <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_rst_ce      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            sample_cnt    <= 16'd0;
            epoch_cnt     <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_status_d  <= bus.status;
            r_in_ready  <= (w_state_nxt == S_FEED);
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_rst_ce    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RSTCE) ||
                           (w_state_nxt == S_DONE);
            busy        <= (w_state_nxt != S_IDLE);
            done        <= (w_state_nxt == S_DONE);

            if (!abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mode        <= mode;
                            r_num_samples <= num_samples;
                            r_num_epochs  <= num_epochs;
                            err_timeout   <= 1'b0;
                            sample_cnt    <= 16'd0;
                            epoch_cnt     <= 8'd0;
                            r_rst_cnt     <= 16'd0;
                        end
                    end
                    S_RSTCE: r_rst_cnt <= r_rst_cnt + 16'd1;
                    S_FEED:  r_run_cnt <= 16'd0;
                    S_RUN: begin
                        if (!w_status_edge && w_run_expired) err_timeout <= 1'b1;
                        else                                 r_run_cnt   <= r_run_cnt + 16'd1;
                    end
                    S_NEXT: begin
                        if (w_last_sample) begin
                            sample_cnt <= 16'd0;
                            if (!(w_last_epoch || !r_mode)) epoch_cnt <= epoch_cnt + 8'd1;
                        end else begin
                            sample_cnt <= sample_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_run_sequencer.sv
//==============================================================================
// Module  : tb_run_sequencer
// Brief   : Directed self-checking bench for run_sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_run_sequencer;

    localparam int unsigned c_RST_CYC = 2;
    localparam logic [15:0] c_TIMEOUT = 16'd20;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        mode;
    logic [15:0] num_samples;
    logic [7:0]  num_epochs;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] sample_cnt;
    logic [7:0]  epoch_cnt;

    run_sequencer_if bus ();

    run_sequencer #(
        .RST_CYC (c_RST_CYC),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .num_samples (num_samples),
        .num_epochs  (num_epochs),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .sample_cnt  (sample_cnt),
        .epoch_cnt   (epoch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event tallies sampled mid-cycle; scenarios diff snapshots of these.
    int n_done  = 0;
    int n_ov    = 0;
    int n_xfer  = 0;
    int n_rstlo = 0;

    always @(negedge clk) begin
        n_done  <= n_done + int'(done);
        n_ov    <= n_ov + int'(bus.out_valid);
        n_xfer  <= n_xfer + int'(bus.in_ready && bus.in_valid);
        n_rstlo <= n_rstlo + int'(!bus.rst_CE);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [15:0] ns, input logic [7:0] ne);
        mode        = m;
        num_samples = ns;
        num_epochs  = ne;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.in_ready), 32'd1);
    endtask

    // One full sample: feed transfer, status edge, optional stalled drain, NEXT.
    task automatic one_sample(input bit infer, input int stall, input int exp_s, input int exp_e);
        wait_in_ready("feed_wait");
        check("feed_sample_cnt", 32'(sample_cnt), 32'(exp_s));
        check("feed_epoch_cnt", 32'(epoch_cnt), 32'(exp_e));
        tick();
        bus.status = 1'b1;
        tick();
        bus.status = 1'b0;
        if (infer) begin
            for (int k = 0; k < stall; k++) begin
                check("drain_stall_valid", 32'(bus.out_valid), 32'd1);
                tick();
            end
            bus.out_ready = 1'b1;
            check("drain_accept_valid", 32'(bus.out_valid), 32'd1);
            tick();
            bus.out_ready = 1'b0;
            check("next_valid_low", 32'(bus.out_valid), 32'd0);
        end
        tick();
    endtask

    int s_done, s_ov, s_xfer, s_rstlo;

    initial begin
        rst            = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        mode           = 1'b0;
        num_samples    = 16'd0;
        num_epochs     = 8'd0;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        bus.request_in = 1'b1;
        bus.status     = 1'b0;
        #12;
        check("rst_rst_CE", 32'(bus.rst_CE), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Training 3 samples x 2 epochs
        s_done = n_done; s_ov = n_ov; s_xfer = n_xfer;
        do_start(1'b1, 16'd3, 8'd2);
        check("tr_rstce_1", 32'(bus.rst_CE), 32'd1);
        check("tr_busy", 32'(busy), 32'd1);
        tick();
        check("tr_rstce_2", 32'(bus.rst_CE), 32'd1);
        tick();
        check("tr_waitreq_rstce", 32'(bus.rst_CE), 32'd0);
        for (int i = 0; i < 6; i++) one_sample(1'b0, 0, i % 3, i / 3);
        check("tr_done", 32'(done), 32'd1);
        check("tr_done_rstce", 32'(bus.rst_CE), 32'd1);
        check("tr_epoch_final", 32'(epoch_cnt), 32'd1);
        check("tr_sample_final", 32'(sample_cnt), 32'd0);
        tick();
        check("tr_idle_done", 32'(done), 32'd0);
        check("tr_idle_busy", 32'(busy), 32'd0);
        tick();
        check("tr_xfers", 32'(n_xfer - s_xfer), 32'd6);
        check("tr_no_out_valid", 32'(n_ov - s_ov), 32'd0);
        check("tr_done_pulses", 32'(n_done - s_done), 32'd1);

        // Inference 2 samples, 5 epochs requested, 4-cycle drain stall
        s_done = n_done; s_ov = n_ov;
        do_start(1'b0, 16'd2, 8'd5);
        for (int i = 0; i < 2; i++) one_sample(1'b1, 4, i, 0);
        check("inf_done", 32'(done), 32'd1);
        check("inf_epoch", 32'(epoch_cnt), 32'd0);
        tick();
        tick();
        check("inf_ov_cycles", 32'(n_ov - s_ov), 32'd10);
        check("inf_done_pulses", 32'(n_done - s_done), 32'd1);

        // Zero samples goes straight to DONE
        s_done = n_done; s_rstlo = n_rstlo;
        do_start(1'b1, 16'd0, 8'd3);
        check("zero_done", 32'(done), 32'd1);
        check("zero_rstce", 32'(bus.rst_CE), 32'd1);
        tick();
        check("zero_idle_done", 32'(done), 32'd0);
        check("zero_idle_busy", 32'(busy), 32'd0);
        tick();
        check("zero_done_pulses", 32'(n_done - s_done), 32'd1);
        check("zero_rstce_low", 32'(n_rstlo - s_rstlo), 32'd0);

        // RUN timeout with status stuck high
        bus.status = 1'b1;
        do_start(1'b1, 16'd1, 8'd1);
        wait_in_ready("to_feed_wait");
        tick();
        repeat (19) tick();
        check("to_pre_done", 32'(done), 32'd0);
        check("to_pre_err", 32'(err_timeout), 32'd0);
        tick();
        check("to_done", 32'(done), 32'd1);
        check("to_err", 32'(err_timeout), 32'd1);
        tick();
        bus.status = 1'b0;
        tick();
        check("to_err_sticky", 32'(err_timeout), 32'd1);

        // abort beats start in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abst_busy", 32'(busy), 32'd0);
        check("abst_err_kept", 32'(err_timeout), 32'd1);

        // Abort during a stalled DRAIN
        do_start(1'b0, 16'd2, 8'd1);
        check("ab_err_cleared", 32'(err_timeout), 32'd0);
        wait_in_ready("ab_feed_wait");
        tick();
        bus.status = 1'b1;
        tick();
        bus.status = 1'b0;
        check("ab_drain_valid", 32'(bus.out_valid), 32'd1);
        s_done = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_out_valid", 32'(bus.out_valid), 32'd0);
        check("ab_rstce", 32'(bus.rst_CE), 32'd1);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        tick();
        check("ab_no_done_pulse", 32'(n_done - s_done), 32'd0);

        // Asynchronous reset during FEED
        do_start(1'b1, 16'd3, 8'd1);
        one_sample(1'b0, 0, 0, 0);
        bus.in_valid = 1'b0;
        wait_in_ready("rs_feed_wait");
        check("rs_pre_sample", 32'(sample_cnt), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rs_in_ready", 32'(bus.in_ready), 32'd0);
        check("rs_rstce", 32'(bus.rst_CE), 32'd1);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_sample", 32'(sample_cnt), 32'd0);
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        do_start(1'b1, 16'd1, 8'd1);
        one_sample(1'b0, 0, 0, 0);
        check("rs_run_done", 32'(done), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
